// File: rtl/regfile_pkg.sv
// Shared constants and address-qualification helper for the register file.
package regfile_pkg;

    // Datapath word width used across the CPU.
    localparam int unsigned WORD_W = 32;

    // True when an address names a real, writable or readable word:
    // inside the array and not the hardwired zero register.
    function automatic logic addr_ok(
        input int unsigned addr,
        input int unsigned depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_muxn.sv
// N-bit 2-way select: o_y = i_sel ? i_b : i_a.
module muxn #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sel,
    output logic [N-1:0] o_y
);

    // Bitwise 2-way select of the two operands.
    always_comb begin
        o_y = i_sel ? i_b : i_a;
    end

endmodule

// File: rtl/regfile_regn.sv
// N-bit storage register with load enable and asynchronous active-high reset.
module regn #(
    parameter int unsigned N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    // Clear immediately on reset; otherwise load i_d when enabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile.sv
// General-purpose register bank: DEPTH words of N bits, one synchronous
// write port, two independent combinational read ports with optional
// write-to-read forwarding and an optional hardwired zero register.
module regfile
    import regfile_pkg::*;
#(
    parameter  int unsigned N        = WORD_W,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [N-1:0]  rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [N-1:0]  rdata_b
);

    // Leaves of the read tree, padded up to a power of two.
    localparam int unsigned P  = 1 << AW;
    localparam logic        ZR = (ZERO_REG != 0);

    logic [N-1:0]  w_word  [DEPTH];
    logic          w_wvalid;
    logic [AW-1:0] w_raddr [2];
    logic [N-1:0]  w_rdata [2];

    // Writes to out-of-range addresses or the zero register are dropped.
    assign w_wvalid = addr_ok(32'(waddr), DEPTH, ZR);

    // Storage: one register per word, one-hot write enable per word.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        if (g == 0 && ZERO_REG != 0) begin : g_zero
            assign w_word[g] = '0;
        end else begin : g_reg
            logic w_wen;
            assign w_wen = we & w_wvalid & (32'(waddr) == g);
            regn #(.N(N)) u_regn (
                .i_clk (clk),
                .i_rst (reset),
                .i_en  (w_wen),
                .i_d   (wdata),
                .o_q   (w_word[g])
            );
        end
    end

    assign w_raddr[0] = raddr_a;
    assign w_raddr[1] = raddr_b;

    // Read ports: heap-indexed binary mux tree (node j selects between
    // 2j and 2j+1), root at index 1, leaves at P..2P-1. Tree level lv
    // is steered by address bit AW-1-lv so leaf P+addr reaches the root.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [N-1:0] w_tree [1:2*P-1];
        logic         w_rvalid;
        logic         w_hit;
        logic [N-1:0] w_sel;
        logic [N-1:0] w_byp;

        for (genvar g = 0; g < P; g++) begin : g_leaf
            if (g < DEPTH) begin : g_in
                assign w_tree[P+g] = w_word[g];
            end else begin : g_pad
                assign w_tree[P+g] = '0;
            end
        end

        for (genvar lv = 0; lv < AW; lv++) begin : g_lvl
            for (genvar j = (1 << lv); j < (2 << lv); j++) begin : g_node
                muxn #(.N(N)) u_mux (
                    .i_a   (w_tree[2*j]),
                    .i_b   (w_tree[2*j+1]),
                    .i_sel (w_raddr[p][AW-1-lv]),
                    .o_y   (w_tree[j])
                );
            end
        end

        assign w_rvalid = addr_ok(32'(w_raddr[p]), DEPTH, ZR);
        assign w_sel    = w_rvalid ? w_tree[1] : '0;
        assign w_hit    = (BYPASS != 0) && we && w_wvalid && (waddr == w_raddr[p]);

        muxn #(.N(N)) u_byp (
            .i_a   (w_sel),
            .i_b   (wdata),
            .i_sel (w_hit),
            .o_y   (w_byp)
        );

        // Reset also masks the forwarded write, which would otherwise leak.
        assign w_rdata[p] = reset ? '0 : w_byp;
    end

    assign rdata_a = w_rdata[0];
    assign rdata_b = w_rdata[1];

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected read values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;

    logic [31:0] rd_a [3];
    logic [31:0] rd_b [3];
    logic [7:0]  s_a  [4];
    logic [7:0]  s_b  [4];

    always #5 clk = ~clk;

    // u0: defaults (zero reg, bypass)
    regfile #(.N(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[0]), .raddr_b(raddr_b), .rdata_b(rd_b[0]));

    // u1: no zero reg, no bypass
    regfile #(.N(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[1]), .raddr_b(raddr_b), .rdata_b(rd_b[1]));

    // u2: non-power-of-two depth, no bypass
    regfile #(.N(32), .DEPTH(20), .ZERO_REG(1), .BYPASS(0)) u2 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[2]), .raddr_b(raddr_b), .rdata_b(rd_b[2]));

    // Small instances: k = {ZERO_REG, BYPASS}
    for (genvar k = 0; k < 4; k++) begin : g_small
        regfile #(.N(8), .DEPTH(16), .ZERO_REG(k / 2), .BYPASS(k % 2)) u (
            .clk(clk), .reset(reset), .we(we), .waddr(waddr[3:0]), .wdata(wdata[7:0]),
            .raddr_a(raddr_a[3:0]), .rdata_a(s_a[k]), .raddr_b(raddr_b[3:0]), .rdata_b(s_b[k]));
    end

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    exp_t        m_e;
    logic [31:0] m_got;
    logic [7:0]  mdl [4][16];

    // Output id: 0..5 -> 32-bit instances (2*inst + port), 6..13 -> small ones.
    function automatic logic [31:0] get_out(int id);
        int k;
        if (id < 6) begin
            return (id % 2 == 1) ? rd_b[id/2] : rd_a[id/2];
        end
        k = (id - 6) / 2;
        return {24'h0, ((id % 2 == 1) ? s_b[k] : s_a[k])};
    endfunction

    task automatic push(int id, logic [31:0] exp, string tag);
        exp_t e;
        e.id  = id;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Same port on u0, u1, u2 with per-instance expectations.
    task automatic exp3(int port, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, string tag);
        push(port, e0, tag);
        push(2 + port, e1, tag);
        push(4 + port, e2, tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_rd(int k, logic [3:0] ra);
        logic zr;
        logic by;
        zr = (k >= 2);
        by = (k % 2 == 1);
        if (zr && ra == 4'd0) return 8'h00;
        if (by && we && waddr[3:0] == ra && !(zr && waddr[3:0] == 4'd0)) return wdata[7:0];
        return mdl[k][ra];
    endfunction

    // Monitor: compare everything queued for this cycle, away from the edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e   = sb.pop_front();
            m_got = get_out(m_e.id);
            checks++;
            if (m_got !== m_e.exp) begin
                errors++;
                $display("FAIL %s (out %0d): got %h expected %h", m_e.tag, m_e.id, m_got, m_e.exp);
            end
        end
    end

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        step();

        // Reset state on every address
        for (int a = 0; a < 32; a++) begin
            raddr_a = 5'(a);
            raddr_b = 5'(31 - a);
            exp3(0, 0, 0, 0, "reset_a");
            exp3(1, 0, 0, 0, "reset_b");
            step();
        end
        reset = 1'b0;
        step();

        // Basic writes, read next cycle
        we = 1'b1; waddr = 5'd3;  wdata = 32'h0000_00A5; step();
        waddr = 5'd31; wdata = 32'hFFFF_0000; step();
        we = 1'b0; raddr_a = 5'd3; raddr_b = 5'd31;
        exp3(0, 32'hA5, 32'hA5, 32'hA5, "wr3");
        exp3(1, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, "wr31");
        step();
        for (int a = 0; a < 31; a++) begin
            if (a != 3) begin
                raddr_a = 5'(a);
                raddr_b = 5'(a);
                exp3(0, 0, 0, 0, "untouched");
                push(1, 0, "untouched_b");
                step();
            end
        end

        // Zero register
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr_a = 5'd0; raddr_b = 5'd3;
        exp3(0, 0, 0, 0, "zr_same");
        step();
        we = 1'b0;
        exp3(0, 0, 32'h1234_5678, 0, "zr_after");
        step();

        // Bypass on both ports, then on one port only
        we = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D; raddr_a = 5'd7; raddr_b = 5'd7;
        exp3(0, 32'hCAFE_F00D, 0, 0, "byp_a");
        exp3(1, 32'hCAFE_F00D, 0, 0, "byp_b");
        step();
        we = 1'b0;
        exp3(0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, "byp_after_a");
        exp3(1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, "byp_after_b");
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111; raddr_a = 5'd7; raddr_b = 5'd3;
        exp3(0, 32'h1111_1111, 32'hCAFE_F00D, 32'hCAFE_F00D, "byp_one_a");
        exp3(1, 32'hA5, 32'hA5, 32'hA5, "byp_one_b");
        step();

        // Out-of-range write on DEPTH=20, boundary word 19
        we = 1'b1; waddr = 5'd25; wdata = 32'h55; raddr_a = 5'd25; raddr_b = 5'd19;
        exp3(0, 32'h55, 0, 0, "oor_same");
        exp3(1, 0, 0, 0, "w19_pre");
        step();
        waddr = 5'd19; wdata = 32'h19;
        exp3(0, 32'h55, 32'h55, 0, "oor_after");
        exp3(1, 32'h19, 0, 0, "w19_same");
        step();
        we = 1'b0; raddr_a = 5'd7; raddr_b = 5'd19;
        exp3(0, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, "keep7");
        exp3(1, 32'h19, 32'h19, 32'h19, "w19");
        step();
        raddr_a = 5'd3; raddr_b = 5'd0;
        exp3(0, 32'hA5, 32'hA5, 32'hA5, "keep3");
        exp3(1, 0, 32'h1234_5678, 0, "keep0");
        step();

        // Mid-run asynchronous reset
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; step();
        we = 1'b0; raddr_a = 5'd5; raddr_b = 5'd6;
        exp3(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "w5");
        step();
        reset = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 32'h66;
        exp3(0, 0, 0, 0, "rst_async_a");
        exp3(1, 0, 0, 0, "rst_async_b");
        step();
        reset = 1'b0; we = 1'b0;
        exp3(0, 0, 0, 0, "rst_after_a");
        exp3(1, 0, 0, 0, "rst_lost_wr");
        step();
        raddr_a = 5'd3; raddr_b = 5'd7;
        exp3(0, 0, 0, 0, "rst_clr3");
        exp3(1, 0, 0, 0, "rst_clr7");
        step();
        we = 1'b1; waddr = 5'd6; wdata = 32'h66; raddr_b = 5'd6;
        exp3(1, 32'h66, 0, 0, "post_rst_same");
        step();
        we = 1'b0;
        exp3(1, 32'h66, 32'h66, 32'h66, "post_rst_wr");
        step();

        // Randomised run on the four N=8, DEPTH=16 configurations
        reset = 1'b1; step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 16; w++)
                mdl[k][w] = 8'h00;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = 5'($urandom_range(0, 15));
            wdata   = $urandom;
            raddr_a = 5'($urandom_range(0, 15));
            raddr_b = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) raddr_a = waddr;
            if ($urandom_range(0, 3) == 0) raddr_b = waddr;
            for (int k = 0; k < 4; k++) begin
                push(6 + 2*k, {24'h0, model_rd(k, raddr_a[3:0])}, "rand_a");
                push(7 + 2*k, {24'h0, model_rd(k, raddr_b[3:0])}, "rand_b");
            end
            step();
            for (int k = 0; k < 4; k++)
                if (we && !((k >= 2) && waddr[3:0] == 4'd0))
                    mdl[k][waddr[3:0]] = wdata[7:0];
        end

        we = 1'b0;
        step();
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
